// File: rtl/wb_bus_arbiter_pkg.sv
// Shared types and constants for the two-master Wishbone arbiter.
package wb_bus_arbiter_pkg;

  localparam int REG_WIDTH = 32;
  localparam int NM        = 2;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'b00,
    ARB_OWN   = 2'b01,
    ARB_ABORT = 2'b11
  } arb_state_e;

endpackage

// File: rtl/wb_arb_watchdog.sv
// Per-transfer watchdog: counts stb cycles without ack and flags expiry,
// plus a one-cycle error pulse on entry into abort.
module wb_arb_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic own_i,
  input  logic stb_i,
  input  logic ack_i,
  input  logic err_i,
  input  logic hold_i,
  output logic expire_o,
  output logic err_o
);

  localparam int          CW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);
  localparam logic        EN    = (TIMEOUT != 0);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;

  // Counter saturates at LIMIT so a stalled owner keeps expire asserted.
  always_comb begin
    cnt_d = cnt_q;
    if (!own_i || ack_i || err_i) cnt_d = '0;
    else if (stb_i && cnt_q != LIMIT) cnt_d = cnt_q + CW'(1);
  end

  assign expire_o = EN && own_i && (cnt_q == LIMIT) && !ack_i;
  assign err_d    = expire_o && hold_i;
  assign err_o    = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

endmodule

// File: rtl/wb_bus_arbiter.sv
// Round-robin arbiter sharing one Wishbone master port between ibus (0)
// and dbus (1); grant held for a whole cyc, watchdog aborts hung transfers.
module wb_bus_arbiter
  import wb_bus_arbiter_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = REG_WIDTH,
  parameter int TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NM-1:0]          m_cyc_i,
  input  logic [NM-1:0]          m_stb_i,
  input  logic [NM-1:0]          m_we_i,
  input  logic [NM-1:0][3:0]     m_sel_i,
  input  logic [NM-1:0][AW-1:0]  m_adr_i,
  input  logic [NM-1:0][DW-1:0]  m_dat_i,
  output logic [DW-1:0]          m_dat_o,
  output logic [NM-1:0]          m_ack_o,
  output logic [NM-1:0]          m_err_o,
  output logic                   s_cyc_o,
  output logic                   s_stb_o,
  output logic                   s_we_o,
  output logic [3:0]             s_sel_o,
  output logic [AW-1:0]          s_adr_o,
  output logic [DW-1:0]          s_dat_o,
  input  logic [DW-1:0]          s_dat_i,
  input  logic                   s_ack_i,
  input  logic                   s_err_i,
  output logic [NM-1:0]          gnt_o
);

  arb_state_e state_q, state_d;
  logic       owner_q, owner_d;
  logic       last_q, last_d;
  logic       winner, own, own_cyc, own_stb;
  logic       expire, err_pulse;

  // On a tie the master not granted last time wins.
  assign winner  = (&m_cyc_i) ? ~last_q : m_cyc_i[1];
  assign own     = (state_q == ARB_OWN);
  assign own_cyc = m_cyc_i[owner_q];
  assign own_stb = m_stb_i[owner_q];

  wb_arb_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .clk      (clk),
    .rst_n    (rst_n),
    .own_i    (own),
    .stb_i    (own_stb),
    .ack_i    (s_ack_i),
    .err_i    (s_err_i),
    .hold_i   (own_cyc),
    .expire_o (expire),
    .err_o    (err_pulse)
  );

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_sel_o = '0;
    s_adr_o = '0;
    s_dat_o = '0;
    gnt_o   = '0;
    m_ack_o = '0;
    m_err_o = '0;
    m_dat_o = s_dat_i;
    unique case (state_q)
      ARB_IDLE: begin
        if (|m_cyc_i) begin
          owner_d = winner;
          last_d  = winner;
          state_d = ARB_OWN;
        end
      end
      ARB_OWN: begin
        s_cyc_o          = own_cyc;
        s_stb_o          = own_stb;
        s_we_o           = m_we_i[owner_q];
        s_sel_o          = m_sel_i[owner_q];
        s_adr_o          = m_adr_i[owner_q];
        s_dat_o          = m_dat_i[owner_q];
        gnt_o[owner_q]   = 1'b1;
        m_ack_o[owner_q] = s_ack_i;
        m_err_o[owner_q] = s_err_i;
        if (!own_cyc)    state_d = ARB_IDLE;
        else if (expire) state_d = ARB_ABORT;
      end
      ARB_ABORT: begin
        // Bus released; grant held until the owner ends its cycle.
        gnt_o[owner_q]   = 1'b1;
        m_err_o[owner_q] = err_pulse;
        if (!own_cyc) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Directed bench for wb_bus_arbiter with TIMEOUT=8.
module tb_wb_bus_arbiter;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [1:0]       m_cyc, m_stb, m_we;
  logic [1:0][3:0]  m_sel;
  logic [1:0][31:0] m_adr, m_dat;
  logic [31:0]      m_dat_o;
  logic [1:0]       m_ack_o, m_err_o, gnt_o;
  logic             s_cyc_o, s_stb_o, s_we_o;
  logic [3:0]       s_sel_o;
  logic [31:0]      s_adr_o, s_dat_o, s_dat_i;
  logic             s_ack_i, s_err_i;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  wb_bus_arbiter #(.AW(32), .DW(32), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we), .m_sel_i(m_sel),
    .m_adr_i(m_adr), .m_dat_i(m_dat), .m_dat_o(m_dat_o),
    .m_ack_o(m_ack_o), .m_err_o(m_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i),
    .s_ack_i(s_ack_i), .s_err_i(s_err_i), .gnt_o(gnt_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    m_cyc = '0; m_stb = '0; m_we = '0; m_sel = '0; m_adr = '0; m_dat = '0;
    s_dat_i = '0; s_ack_i = 1'b0; s_err_i = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    #3;
    n_chk++;
    if ({s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o, gnt_o, m_ack_o, m_err_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got cyc=%b gnt=%b ack=%b err=%b, want all 0", s_cyc_o, gnt_o, m_ack_o, m_err_o);
    end
    tick();
    rst_n = 1'b1;
    tick();
    n_chk++;
    if (gnt_o !== 2'b00) begin n_fail++; $display("FAIL reset_idle_gnt: got %b want 00", gnt_o); end
  endtask

  task automatic test_tie();
    do_reset();
    m_cyc = 2'b11;
    tick();
    n_chk++;
    if (gnt_o !== 2'b01) begin n_fail++; $display("FAIL tie_first: got %b want 01", gnt_o); end
    m_cyc = 2'b10;
    tick();
    n_chk++;
    if (gnt_o !== 2'b00 || s_cyc_o !== 1'b0) begin n_fail++; $display("FAIL tie_bubble: got gnt=%b cyc=%b want 00/0", gnt_o, s_cyc_o); end
    tick();
    n_chk++;
    if (gnt_o !== 2'b10 || s_cyc_o !== 1'b1) begin n_fail++; $display("FAIL tie_second: got gnt=%b cyc=%b want 10/1", gnt_o, s_cyc_o); end
    m_cyc = 2'b00;
    tick();
    m_cyc = 2'b11;
    tick();
    n_chk++;
    if (gnt_o !== 2'b01) begin n_fail++; $display("FAIL tie_alternate: got %b want 01", gnt_o); end
    clear_inputs();
    tick();
    tick();
  endtask

  task automatic test_single_read();
    m_cyc = 2'b01; m_stb = 2'b01; m_sel[0] = 4'hF; m_adr[0] = 32'h0000_0100;
    m_adr[1] = 32'h0000_0200;
    #1;
    n_chk++;
    if (s_cyc_o !== 1'b0) begin n_fail++; $display("FAIL read_t0_cyc: got %b want 0", s_cyc_o); end
    tick();
    n_chk++;
    if (s_cyc_o !== 1'b1 || gnt_o !== 2'b01 || s_adr_o !== 32'h0000_0100 || s_sel_o !== 4'hF || s_we_o !== 1'b0)
    begin
      n_fail++;
      $display("FAIL read_t1_bus: got cyc=%b gnt=%b adr=%h sel=%h we=%b want 1/01/00000100/f/0", s_cyc_o, gnt_o, s_adr_o, s_sel_o, s_we_o);
    end
    tick();
    tick();
    s_ack_i = 1'b1; s_dat_i = 32'hDEAD_BEEF;
    #1;
    n_chk++;
    if (m_ack_o !== 2'b01 || m_err_o !== 2'b00) begin n_fail++; $display("FAIL read_t3_ack: got ack=%b err=%b want 01/00", m_ack_o, m_err_o); end
    n_chk++;
    if (m_dat_o !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL read_t3_data: got %h want deadbeef", m_dat_o); end
    tick();
    clear_inputs();
    tick();
    n_chk++;
    if (gnt_o !== 2'b00) begin n_fail++; $display("FAIL read_release: got %b want 00", gnt_o); end
  endtask

  task automatic test_no_preempt();
    m_cyc = 2'b10; m_stb = 2'b10; m_we = 2'b10; m_sel[1] = 4'h3;
    m_adr[1] = 32'h0000_0040; m_dat[1] = 32'hCAFE_F00D; m_dat[0] = 32'h1111_1111;
    tick();
    n_chk++;
    if (gnt_o !== 2'b10 || s_we_o !== 1'b1 || s_dat_o !== 32'hCAFE_F00D || s_sel_o !== 4'h3)
    begin
      n_fail++;
      $display("FAIL preempt_write: got gnt=%b we=%b dat=%h sel=%h want 10/1/cafef00d/3", gnt_o, s_we_o, s_dat_o, s_sel_o);
    end
    m_cyc = 2'b11; m_stb = 2'b11;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_chk++;
      if (gnt_o !== 2'b10 || m_ack_o !== 2'b00) begin n_fail++; $display("FAIL preempt_hold%0d: got gnt=%b ack=%b want 10/00", i, gnt_o, m_ack_o); end
    end
    s_ack_i = 1'b1;
    #1;
    n_chk++;
    if (m_ack_o !== 2'b10) begin n_fail++; $display("FAIL preempt_ack_route: got %b want 10", m_ack_o); end
    s_ack_i = 1'b0;
    m_cyc = 2'b01; m_stb = 2'b01;
    tick();
    n_chk++;
    if (gnt_o !== 2'b00) begin n_fail++; $display("FAIL preempt_bubble: got %b want 00", gnt_o); end
    tick();
    n_chk++;
    if (gnt_o !== 2'b01 || s_dat_o !== 32'h1111_1111) begin n_fail++; $display("FAIL preempt_handover: got gnt=%b dat=%h want 01/11111111", gnt_o, s_dat_o); end
    clear_inputs();
    tick();
    tick();
  endtask

  task automatic test_timeout();
    m_cyc = 2'b01; m_stb = 2'b01;
    for (int k = 1; k <= 9; k++) begin
      tick();
      n_chk++;
      if (s_cyc_o !== 1'b1 || m_err_o !== 2'b00) begin n_fail++; $display("FAIL timeout_pre_t%0d: got cyc=%b err=%b want 1/00", k, s_cyc_o, m_err_o); end
    end
    tick();
    n_chk++;
    if (m_err_o !== 2'b01 || s_cyc_o !== 1'b0 || gnt_o !== 2'b01) begin n_fail++; $display("FAIL timeout_abort: got err=%b cyc=%b gnt=%b want 01/0/01", m_err_o, s_cyc_o, gnt_o); end
    tick();
    n_chk++;
    if (m_err_o !== 2'b00 || s_cyc_o !== 1'b0 || gnt_o !== 2'b01) begin n_fail++; $display("FAIL timeout_hold: got err=%b cyc=%b gnt=%b want 00/0/01", m_err_o, s_cyc_o, gnt_o); end
    m_cyc = 2'b00; m_stb = 2'b00;
    tick();
    n_chk++;
    if (gnt_o !== 2'b00) begin n_fail++; $display("FAIL timeout_idle: got %b want 00", gnt_o); end
    clear_inputs();
    tick();
  endtask

  task automatic test_ack_at_limit();
    m_cyc = 2'b01; m_stb = 2'b01;
    for (int k = 1; k <= 9; k++) tick();
    s_ack_i = 1'b1;
    #1;
    n_chk++;
    if (m_ack_o !== 2'b01 || m_err_o !== 2'b00) begin n_fail++; $display("FAIL limit_ack: got ack=%b err=%b want 01/00", m_ack_o, m_err_o); end
    tick();
    s_ack_i = 1'b0;
    #1;
    n_chk++;
    if (s_cyc_o !== 1'b1 || gnt_o !== 2'b01 || m_err_o !== 2'b00) begin n_fail++; $display("FAIL limit_stay_own: got cyc=%b gnt=%b err=%b want 1/01/00", s_cyc_o, gnt_o, m_err_o); end
    tick();
    n_chk++;
    if (s_cyc_o !== 1'b1 || m_err_o !== 2'b00) begin n_fail++; $display("FAIL limit_wd_cleared: got cyc=%b err=%b want 1/00", s_cyc_o, m_err_o); end
    clear_inputs();
    tick();
    tick();
  endtask

  task automatic test_async_reset();
    m_cyc = 2'b01; m_stb = 2'b01;
    tick();
    s_ack_i = 1'b1;
    #1;
    n_chk++;
    if (m_ack_o !== 2'b01 || s_cyc_o !== 1'b1) begin n_fail++; $display("FAIL arst_pre: got ack=%b cyc=%b want 01/1", m_ack_o, s_cyc_o); end
    #1;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (s_cyc_o !== 1'b0 || gnt_o !== 2'b00 || m_ack_o !== 2'b00) begin n_fail++; $display("FAIL arst_immediate: got cyc=%b gnt=%b ack=%b want 0/00/00", s_cyc_o, gnt_o, m_ack_o); end
    #1;
    s_ack_i = 1'b0;
    m_cyc = 2'b11; m_stb = 2'b00;
    rst_n = 1'b1;
    tick();
    n_chk++;
    if (gnt_o !== 2'b01) begin n_fail++; $display("FAIL arst_tie: got %b want 01", gnt_o); end
    clear_inputs();
    tick();
  endtask

  initial begin
    test_reset();
    test_tie();
    test_single_read();
    test_no_preempt();
    test_timeout();
    test_ack_at_limit();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
